// File: rtl/sync_echo_pkg.sv
// Shared types and helpers for the sync_echo auto-sync responder.
package sync_echo_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RX_HIGH = 3'd2,
        DELAY   = 3'd3,
        TX      = 3'd4,
        BLANK   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int DEF_TIME_BITS = 8;
    localparam int TIME_MAX      = (1 << DEF_TIME_BITS) - 1;

    // Accepted input widths lie in the closed range [lo, hi].
    function automatic logic width_ok(input int w, input int lo, input int hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous pin with registered rise/fall strobes.
module sync_edge_det #(
    parameter int SYNC = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC-1:0] r_sync;
    logic r_last;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_last <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], i_din};
            r_last <= r_sync[SYNC-1];
            r_rise <= r_sync[SYNC-1] & ~r_last;
            r_fall <= ~r_sync[SYNC-1] & r_last;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/sync_echo.sv
// sync_echo: validates each sync pulse from the primary board and re-emits a clean,
// fixed-length echo after a programmable delay so the primary can time the round trip.
module sync_echo
    import sync_echo_pkg::*;
#(
    parameter int PULSE_LENGTH = 3,
    parameter int PULSE_WAIT   = 5,
    parameter int PULSE_NUM    = 2,
    parameter int PULSE_MIN    = 1,
    parameter int PULSE_MAX    = 6,
    parameter int TIME_BITS    = DEF_TIME_BITS,
    parameter int DELAY_BITS   = 10,
    parameter int SYNC         = 2
) (
    input  logic                  i_clock_bus,
    input  logic                  i_reset_bus,
    input  logic                  i_as_en,
    input  logic                  i_sync_in,
    input  logic [DELAY_BITS-1:0] i_echo_delay,
    output logic                  o_sync_out,
    output logic                  o_trg_out,
    output logic                  o_as_active,
    output logic                  o_as_done,
    output logic                  o_as_timeout,
    output logic                  o_as_error,
    output logic [TIME_BITS-1:0]  o_pulse_count,
    output logic [TIME_BITS-1:0]  o_rx_width,
    output logic [TIME_BITS-1:0]  o_rx_time
);

    localparam int LW       = $clog2(((PULSE_LENGTH > PULSE_WAIT) ? PULSE_LENGTH : PULSE_WAIT) + 1);
    localparam int CNT_BITS = (DELAY_BITS > LW) ? DELAY_BITS : LW;
    localparam logic [TIME_BITS-1:0] T_MAX  = '1;
    localparam logic [TIME_BITS-1:0] T_PRE  = T_MAX - 1'b1;
    localparam logic [TIME_BITS-1:0] C_NUM  = TIME_BITS'(PULSE_NUM);
    localparam logic [CNT_BITS-1:0]  C_LEN  = CNT_BITS'(PULSE_LENGTH);
    localparam logic [CNT_BITS-1:0]  C_WAIT = CNT_BITS'(PULSE_WAIT);

    state_t r_state, w_next;
    logic w_rise, w_fall;
    logic w_arm, w_accept, w_tmo, w_finish;
    logic [TIME_BITS-1:0] w_count_inc;

    logic                  r_en_prev;
    logic [DELAY_BITS-1:0] r_delay;
    logic [CNT_BITS-1:0]   r_cnt;
    logic [TIME_BITS-1:0]  r_arm_tmr, r_width, r_count, r_rx_width, r_rx_time;
    logic r_error, r_timeout, r_sync_out, r_trg, r_active, r_done;

    sync_edge_det #(.SYNC(SYNC)) u_edge (
        .i_clk  (i_clock_bus),
        .i_rst  (i_reset_bus),
        .i_din  (i_sync_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_count_inc = (r_count == T_MAX) ? r_count : r_count + 1'b1;

    always_ff @(posedge i_clock_bus) begin
        if (i_reset_bus) r_state <= IDLE;
        else             r_state <= w_next;
    end

    // Dropping the enable outranks everything; timeout outranks a same-cycle rise.
    always_comb begin
        w_next   = r_state;
        w_arm    = 1'b0;
        w_accept = 1'b0;
        w_tmo    = 1'b0;
        w_finish = 1'b0;
        if (r_state != IDLE && !i_as_en) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (i_as_en && !r_en_prev) begin
                    w_next = ARMED;
                    w_arm  = 1'b1;
                end
                ARMED: begin
                    if (r_arm_tmr >= T_PRE) begin
                        w_tmo  = 1'b1;
                        w_next = DONE;
                    end else if (w_rise) begin
                        w_next = RX_HIGH;
                    end
                end
                RX_HIGH: if (w_fall) begin
                    if (width_ok(int'(r_width), PULSE_MIN, PULSE_MAX)) begin
                        w_accept = 1'b1;
                        w_next   = (r_delay == '0) ? TX : DELAY;
                    end else begin
                        w_next = ARMED;
                    end
                end
                DELAY: if (r_cnt <= 1) w_next = TX;
                TX:    if (r_cnt <= 1) w_next = BLANK;
                BLANK: if (r_cnt <= 1) begin
                    w_finish = 1'b1;
                    w_next   = (w_count_inc == C_NUM) ? DONE : ARMED;
                end
                DONE:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock_bus) begin
        if (i_reset_bus) begin
            r_en_prev  <= 1'b0;
            r_delay    <= '0;
            r_cnt      <= '0;
            r_arm_tmr  <= '0;
            r_width    <= '0;
            r_count    <= '0;
            r_rx_width <= '0;
            r_rx_time  <= '0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
            r_sync_out <= 1'b0;
            r_trg      <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_en_prev  <= i_as_en;
            r_sync_out <= (w_next == TX);
            r_trg      <= (w_next == DONE) && (r_state != DONE);
            r_active   <= (w_next != IDLE) && (w_next != DONE);
            r_done     <= (w_next == DONE);

            if ((r_state == ARMED || r_state == RX_HIGH) && r_arm_tmr != T_MAX)
                r_arm_tmr <= r_arm_tmr + 1'b1;
            if (r_state == RX_HIGH && w_next == RX_HIGH && r_width != T_MAX)
                r_width <= r_width + 1'b1;
            if (r_state == ARMED && w_next == RX_HIGH) begin
                r_width <= TIME_BITS'(1);
                if (r_count == '0) r_rx_time <= r_arm_tmr;
            end
            if (r_state == RX_HIGH && w_fall && w_next == ARMED) r_error <= 1'b1;
            if (w_tmo) r_timeout <= 1'b1;

            if (r_state == DELAY || r_state == TX || r_state == BLANK) r_cnt <= r_cnt - 1'b1;
            if (r_state == DELAY && w_next == TX)  r_cnt <= C_LEN;
            if (r_state == TX && w_next == BLANK)  r_cnt <= C_WAIT;
            if (w_accept) begin
                r_rx_width <= r_width;
                r_arm_tmr  <= '0;
                r_cnt      <= (r_delay == '0) ? C_LEN : CNT_BITS'(r_delay);
            end
            if (w_finish) r_count <= w_count_inc;

            if (w_arm) begin
                r_delay    <= i_echo_delay;
                r_cnt      <= '0;
                r_arm_tmr  <= '0;
                r_width    <= '0;
                r_count    <= '0;
                r_rx_width <= '0;
                r_rx_time  <= '0;
                r_error    <= 1'b0;
                r_timeout  <= 1'b0;
            end
        end
    end

    assign o_sync_out    = r_sync_out;
    assign o_trg_out     = r_trg;
    assign o_as_active   = r_active;
    assign o_as_done     = r_done;
    assign o_as_timeout  = r_timeout;
    assign o_as_error    = r_error;
    assign o_pulse_count = r_count;
    assign o_rx_width    = r_rx_width;
    assign o_rx_time     = r_rx_time;

endmodule

// File: tb/tb_sync_echo.sv
// Bench for sync_echo: random pulse trains scored against an event-level echo model.
module tb_sync_echo;

    typedef struct {
        int start;
        int len;
    } echo_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, en4 = 1'b0;
    logic prim = 1'b0, lb_en = 1'b0, lb_d = 1'b0;
    logic [9:0] dly = '0;
    logic sin;
    logic sout, trg, act, done, tmo, err;
    logic [7:0] cnt, rxw, rxt;
    logic sout4, trg4, act4, done4, tmo4, err4;
    logic [3:0] cnt4, rxw4, rxt4;

    int cyc = 0;
    int checks = 0, failures = 0;
    int trg_cnt = 0, trg4_cnt = 0;
    echo_t exp_q[$];

    // Reference model state
    int exp_count, exp_rxw, exp_rxt, exp_trg, arm_cyc, cur_delay;
    logic exp_err, exp_done;

    assign sin = prim | (lb_en & lb_d);

    sync_echo dut (
        .i_clock_bus(clk), .i_reset_bus(rst), .i_as_en(en), .i_sync_in(sin),
        .i_echo_delay(dly), .o_sync_out(sout), .o_trg_out(trg), .o_as_active(act),
        .o_as_done(done), .o_as_timeout(tmo), .o_as_error(err),
        .o_pulse_count(cnt), .o_rx_width(rxw), .o_rx_time(rxt)
    );

    sync_echo #(.TIME_BITS(4)) dut4 (
        .i_clock_bus(clk), .i_reset_bus(rst), .i_as_en(en4), .i_sync_in(1'b0),
        .i_echo_delay(dly), .o_sync_out(sout4), .o_trg_out(trg4), .o_as_active(act4),
        .o_as_done(done4), .o_as_timeout(tmo4), .o_as_error(err4),
        .o_pulse_count(cnt4), .o_rx_width(rxw4), .o_rx_time(rxt4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) lb_d <= sout;

    task automatic chk(input string nm, input int act_v, input int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm(input int d);
        en = 1'b0;
        step(2);
        dly = 10'(d);
        en = 1'b1;
        arm_cyc   = cyc + 1;
        cur_delay = d;
        exp_count = 0; exp_rxw = 0; exp_rxt = 0;
        exp_err   = 1'b0; exp_done = 1'b0;
        step(1);
    endtask

    // Width 0 is a sub-cycle glitch that no clock edge sees.
    task automatic pulse(input int w, input int gap);
        int c, f;
        echo_t e;
        if (w == 0) begin
            prim = 1'b1;
            #2;
            prim = 1'b0;
        end else begin
            c = cyc;
            prim = 1'b1;
            step(w);
            f = cyc;
            prim = 1'b0;
            if (!exp_done) begin
                if (w >= 1 && w <= 6) begin
                    if (exp_count == 0) exp_rxt = c + 3 - arm_cyc;
                    exp_rxw = w;
                    e.start = f + 4 + cur_delay;
                    e.len   = 3;
                    exp_q.push_back(e);
                    exp_count++;
                    if (exp_count == 2) begin
                        exp_done = 1'b1;
                        exp_trg++;
                    end
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        step(gap);
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"}, int'(cnt), exp_count);
        chk({tag, ".rx_width"}, int'(rxw), exp_rxw);
        chk({tag, ".rx_time"}, int'(rxt), exp_rxt);
        chk({tag, ".error"}, int'(err), int'(exp_err));
        chk({tag, ".done"}, int'(done), int'(exp_done));
        chk({tag, ".timeout"}, int'(tmo), 0);
        chk({tag, ".trg_count"}, trg_cnt, exp_trg);
        chk({tag, ".echo_pending"}, exp_q.size(), 0);
    endtask

    // Monitor: scores each echo against the queue and enforces one-cycle trigger pulses.
    initial begin
        logic p_so, p_trg, p_trg4;
        int st;
        echo_t e;
        p_so = 1'b0; p_trg = 1'b0; p_trg4 = 1'b0; st = 0;
        forever begin
            @(negedge clk);
            if (sout && !p_so) st = cyc;
            if (!sout && p_so) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_echo: start %0d len %0d, none expected", st, cyc - st);
                end else begin
                    e = exp_q.pop_front();
                    chk("echo_start", st, e.start);
                    chk("echo_len", cyc - st, e.len);
                end
            end
            if (p_trg)  chk("trg_width", int'(trg), 0);
            if (p_trg4) chk("trg4_width", int'(trg4), 0);
            if (trg && !p_trg) trg_cnt++;
            if (trg4 && !p_trg4) trg4_cnt++;
            p_so = sout; p_trg = trg; p_trg4 = trg4;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int f, s, a, got, w1, w2, d;
        echo_t e;
        exp_trg = 0;
        step(3);
        chk("reset.outputs", int'({sout, trg, act, done, tmo, err}), 0);
        chk("reset.counters", int'({cnt, rxw, rxt}), 0);
        rst = 1'b0;
        step(2);

        // Fixed delay, two good pulses
        arm(4);
        chk("armed.active", int'(act), 1);
        pulse(3, 40);
        pulse(3, 40);
        check_status("t1");

        // Zero delay: echo right after the fall strobe
        arm(0);
        pulse(3, 20);
        check_status("t2");
        chk("t2.active", int'(act), 1);

        // Bad widths then one good pulse
        arm(4);
        pulse(0, 5);
        pulse(7, 8);
        pulse(20, 8);
        pulse(3, 30);
        check_status("t3");

        // Echo looped back onto the input must be ignored
        lb_en = 1'b1;
        arm(int'($urandom_range(0, 12)));
        pulse(3, cur_delay + 20);
        pulse(int'($urandom_range(1, 6)), cur_delay + 20);
        check_status("t4");
        lb_en = 1'b0;

        // Randomized trains, sometimes led by an over-long pulse
        repeat (4) begin
            d = int'($urandom_range(0, 30));
            arm(d);
            if ($urandom_range(0, 1) == 1) pulse(int'($urandom_range(7, 12)), 6);
            w1 = int'($urandom_range(1, 6));
            w2 = int'($urandom_range(1, 6));
            pulse(w1, d + 15 + int'($urandom_range(0, 10)));
            pulse(w2, d + 15 + int'($urandom_range(0, 10)));
            check_status("rand");
        end

        // Timeout on the 4-bit instance
        en4 = 1'b1;
        a = cyc;
        got = -1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (done4) begin
                got = cyc - (a + 1);
                break;
            end
        end
        chk("t5.timeout_latency", got, 15);
        chk("t5.timeout", int'(tmo4), 1);
        chk("t5.active", int'(act4), 0);
        step(3);
        chk("t5.trg_count", trg4_cnt, 1);
        en4 = 1'b0;
        step(2);
        chk("t5.idle_done", int'(done4), 0);
        chk("t5.timeout_held", int'(tmo4), 1);

        // Enable dropped mid-echo: echo truncated, count held
        arm(6);
        pulse(3, 25);
        prim = 1'b1;
        step(3);
        f = cyc;
        prim = 1'b0;
        s = f + 4 + 6;
        e.start = s;
        e.len = 2;
        exp_q.push_back(e);
        step(s + 1 - cyc);
        en = 1'b0;
        step(1);
        chk("t6.sync_out", int'(sout), 0);
        chk("t6.active", int'(act), 0);
        chk("t6.done", int'(done), 0);
        chk("t6.count", int'(cnt), 1);
        step(3);
        chk("t6.echo_pending", exp_q.size(), 0);

        // Reset during DELAY clears every output on the next edge
        arm(10);
        prim = 1'b1;
        step(3);
        f = cyc;
        prim = 1'b0;
        step(f + 6 - cyc);
        chk("t6.in_delay", int'(act), 1);
        rst = 1'b1;
        en = 1'b0;
        step(1);
        chk("t6.rst_outputs", int'({sout, trg, act, done, tmo, err}), 0);
        chk("t6.rst_counters", int'({cnt, rxw, rxt}), 0);
        rst = 1'b0;
        step(30);
        chk("t6.no_echo_after_rst", int'(sout), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
